fp_divider: RTL and testbench

Sequential IEEE-754 floating-point divider computing `out = a / b`. It is the inverse-operation companion to the floating-point multiplier in the FPU datapath and uses the same `X`/`expo_bits`/`mant_bits` parameterisation and the same special-case conventions. A start/done handshake fronts a radix-2 restoring mantissa divider, followed by normalisation and round-to-nearest-even.

---
 rtl/fp_divider.sv | 235 +++++++++++++++++++++++
 tb/tb_fp_divider.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/fp_divider.sv
// fp_divider: sequential IEEE-754 divider (restoring radix-2 mantissa core, round-to-nearest-even).
// Define FP_DIV_SUBNORMAL_EN for subnormal inputs/outputs; without it subnormals flush to signed zero.
module fp_divider #(
    parameter int X         = 32,
    parameter int expo_bits = 8,
    parameter int mant_bits = 23
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic [X-1:0] i_a,
    input  logic [X-1:0] i_b,
    output logic [X-1:0] o_out,
    output logic         o_done,
    output logic         o_busy,
    output logic         o_invalid,
    output logic         o_div_by_zero,
    output logic         o_overflow,
    output logic         o_underflow
);
    localparam int M  = mant_bits + 1;
    localparam int Q  = mant_bits + 3;
    localparam int EW = expo_bits + 2;
    localparam int CW = $clog2(Q + 1);
    localparam logic signed [EW-1:0] BIAS    = EW'((1 << (expo_bits - 1)) - 1);
    localparam logic signed [EW-1:0] EXP_MAX = EW'((1 << expo_bits) - 1);
    localparam logic signed [EW-1:0] E_ONE   = EW'(1);
    localparam logic [CW-1:0]        CNT_LD  = CW'(Q - 1);
    localparam logic [X-1:0]         QBIT    = X'(1) << (mant_bits - 1);
    localparam logic [X-1:0]         DEF_NAN = {1'b0, {expo_bits{1'b1}}, 1'b1, {(mant_bits-1){1'b0}}};

    // IDLE wait | UNPACK classify | PRENORM align subnormals | DIVIDE quotient bits | NORM | ROUND commit | FINISH done
    typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_PRENORM, S_DIVIDE, S_NORM, S_ROUND, S_FINISH} state_t;
    state_t r_state, w_next;

    logic [X-1:0]           r_a, r_b, r_out;
    logic [M:0]             r_ma;
    logic [M-1:0]           r_mb;
    logic signed [EW-1:0]   r_ea, r_eb, r_e;
    logic [Q-1:0]           r_q;
    logic [CW-1:0]          r_cnt;
    logic                   r_sticky, r_uf_zero;
    logic                   r_inv, r_dbz, r_ovf, r_unf;

    logic [expo_bits-1:0]   w_ea_f, w_eb_f;
    logic [mant_bits-1:0]   w_fa, w_fb;
    logic                   w_sign, w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
    logic                   w_special, w_sp_inv, w_sp_dbz;
    logic [X-1:0]           w_sp_out, w_inf;
    logic [M:0]             w_ua_m, w_sub;
    logic [M-1:0]           w_ub_m;
    logic signed [EW-1:0]   w_ua_e, w_ub_e, w_en, w_ef;
    logic                   w_pre_last, w_ge, w_tiny, w_st, w_up, w_inexact, w_ovf;
    logic [Q-1:0]           w_qn;
    logic [M:0]             w_rm;

    assign w_ea_f   = r_a[X-2 -: expo_bits];
    assign w_eb_f   = r_b[X-2 -: expo_bits];
    assign w_fa     = r_a[mant_bits-1:0];
    assign w_fb     = r_b[mant_bits-1:0];
    assign w_sign   = r_a[X-1] ^ r_b[X-1];
    assign w_inf    = {w_sign, {expo_bits{1'b1}}, {mant_bits{1'b0}}};
    assign w_a_nan  = (&w_ea_f) & (|w_fa);
    assign w_b_nan  = (&w_eb_f) & (|w_fb);
    assign w_a_inf  = (&w_ea_f) & ~(|w_fa);
    assign w_b_inf  = (&w_eb_f) & ~(|w_fb);
`ifdef FP_DIV_SUBNORMAL_EN
    assign w_a_zero = ~(|w_ea_f) & ~(|w_fa);
    assign w_b_zero = ~(|w_eb_f) & ~(|w_fb);
`else
    assign w_a_zero = ~(|w_ea_f);
    assign w_b_zero = ~(|w_eb_f);
`endif

    always_comb begin
        w_special = 1'b1;
        w_sp_out  = '0;
        w_sp_inv  = 1'b0;
        w_sp_dbz  = 1'b0;
        if (w_a_nan) begin
            w_sp_out = r_a | QBIT;
            w_sp_inv = 1'b1;
        end else if (w_b_nan) begin
            w_sp_out = r_b | QBIT;
            w_sp_inv = 1'b1;
        end else if ((w_a_zero & w_b_zero) | (w_a_inf & w_b_inf)) begin
            w_sp_out = DEF_NAN;
            w_sp_inv = 1'b1;
        end else if (w_a_inf) begin
            w_sp_out = w_inf;
        end else if (w_b_zero) begin
            w_sp_out = w_inf;
            w_sp_dbz = 1'b1;
        end else if (w_a_zero | w_b_inf) begin
            w_sp_out = {w_sign, {(X-1){1'b0}}};
        end else begin
            w_special = 1'b0;
        end
    end

    // Exponent field 0 behaves as exponent 1 with a clear hidden bit.
    assign w_ua_m     = {1'b0, |w_ea_f, w_fa};
    assign w_ub_m     = {|w_eb_f, w_fb};
    assign w_ua_e     = (|w_ea_f) ? {2'b00, w_ea_f} : E_ONE;
    assign w_ub_e     = (|w_eb_f) ? {2'b00, w_eb_f} : E_ONE;
    assign w_pre_last = r_ma[M-1] ? r_mb[M-2] : (r_ma[M-2] & r_mb[M-1]);

    assign w_ge   = r_ma >= {1'b0, r_mb};
    assign w_sub  = r_ma - {1'b0, r_mb};

    assign w_qn   = r_q[Q-1] ? r_q : (r_q << 1);
    assign w_en   = r_q[Q-1] ? r_e : (r_e - E_ONE);
    assign w_tiny = w_en[EW-1] | (w_en == '0);
    assign w_st   = |r_ma;
`ifdef FP_DIV_SUBNORMAL_EN
    logic [EW-1:0] w_nsh;
    logic [Q-1:0]  w_qs, w_mask;
    assign w_nsh  = E_ONE - w_en;
    assign w_qs   = w_qn >> w_nsh;
    assign w_mask = ~({Q{1'b1}} << w_nsh);
`endif

    // r_q: hidden bit at Q-1, fraction below it, then guard and round.
    assign w_up      = r_q[1] & (r_q[0] | r_sticky | r_q[2]);
    assign w_inexact = r_q[1] | r_q[0] | r_sticky;
    assign w_rm      = {1'b0, r_q[Q-1:2]} + {{M{1'b0}}, w_up};
    assign w_ef      = (r_e == '0) ? {{(EW-1){1'b0}}, w_rm[M-1]} : (r_e + {{(EW-1){1'b0}}, w_rm[M]});
    assign w_ovf     = w_ef >= EXP_MAX;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (i_start) w_next = S_UNPACK;
`ifdef FP_DIV_SUBNORMAL_EN
            S_UNPACK:  w_next = w_special ? S_ROUND :
                                (w_ua_m[M-1] & w_ub_m[M-1]) ? S_DIVIDE : S_PRENORM;
`else
            S_UNPACK:  w_next = w_special ? S_ROUND : S_DIVIDE;
`endif
            S_PRENORM: if (w_pre_last) w_next = S_DIVIDE;
            S_DIVIDE:  if (r_cnt == '0) w_next = S_NORM;
            S_NORM:    w_next = S_ROUND;
            S_ROUND:   w_next = S_FINISH;
            S_FINISH:  w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_a <= '0; r_b <= '0; r_out <= '0;
            r_ma <= '0; r_mb <= '0; r_ea <= '0; r_eb <= '0; r_e <= '0;
            r_q <= '0; r_cnt <= '0; r_sticky <= 1'b0; r_uf_zero <= 1'b0;
            r_inv <= 1'b0; r_dbz <= 1'b0; r_ovf <= 1'b0; r_unf <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (i_start) begin
                    r_a <= i_a;
                    r_b <= i_b;
                end
                S_UNPACK: begin
                    r_ma  <= w_ua_m;
                    r_mb  <= w_ub_m;
                    r_ea  <= w_ua_e;
                    r_eb  <= w_ub_e;
                    r_cnt <= CNT_LD;
                    r_q   <= '0;
                end
                S_PRENORM: if (!r_ma[M-1]) begin
                    r_ma <= r_ma << 1;
                    r_ea <= r_ea - E_ONE;
                end else begin
                    r_mb <= r_mb << 1;
                    r_eb <= r_eb - E_ONE;
                end
                S_DIVIDE: begin
                    r_ma  <= (w_ge ? w_sub : r_ma) << 1;
                    r_q   <= {r_q[Q-2:0], w_ge};
                    r_cnt <= r_cnt - CW'(1);
                    r_e   <= r_ea - r_eb + BIAS;
                end
                S_NORM: begin
`ifdef FP_DIV_SUBNORMAL_EN
                    if (w_tiny) begin
                        r_q      <= w_qs;
                        r_sticky <= w_st | (|(w_qn & w_mask));
                        r_e      <= '0;
                    end else begin
                        r_q      <= w_qn;
                        r_sticky <= w_st;
                        r_e      <= w_en;
                    end
                    r_uf_zero <= 1'b0;
`else
                    r_q       <= w_qn;
                    r_sticky  <= w_st;
                    r_e       <= w_en;
                    r_uf_zero <= w_tiny;
`endif
                end
                S_ROUND: begin
                    r_inv <= 1'b0; r_dbz <= 1'b0; r_ovf <= 1'b0; r_unf <= 1'b0;
                    if (w_special) begin
                        r_out <= w_sp_out;
                        r_inv <= w_sp_inv;
                        r_dbz <= w_sp_dbz;
                    end else if (r_uf_zero) begin
                        r_out <= {w_sign, {(X-1){1'b0}}};
                        r_unf <= 1'b1;
                    end else if (w_ovf) begin
                        r_out <= w_inf;
                        r_ovf <= 1'b1;
                    end else begin
                        r_out <= {w_sign, w_ef[expo_bits-1:0], w_rm[M-2:0]};
                        r_unf <= (w_ef == '0) & w_inexact;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_out         = r_out;
    assign o_done        = (r_state == S_FINISH);
    assign o_busy        = (r_state != S_IDLE);
    assign o_invalid     = r_inv;
    assign o_div_by_zero = r_dbz;
    assign o_overflow    = r_ovf;
    assign o_underflow   = r_unf;
endmodule

// File: tb/tb_fp_divider.sv
// tb_fp_divider: directed and randomized checks of fp_divider against an integer-arithmetic reference.
module tb_fp_divider;
    logic        i_clk = 1'b0;
    logic        i_rst, i_start;
    logic [31:0] i_a, i_b, o_out;
    logic        o_done, o_busy, o_invalid, o_div_by_zero, o_overflow, o_underflow;
    int          n_chk = 0;
    int          n_err = 0;

`ifdef FP_DIV_SUBNORMAL_EN
    localparam bit SUB = 1'b1;
`else
    localparam bit SUB = 1'b0;
`endif

    fp_divider dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_a(i_a), .i_b(i_b),
        .o_out(o_out), .o_done(o_done), .o_busy(o_busy), .o_invalid(o_invalid),
        .o_div_by_zero(o_div_by_zero), .o_overflow(o_overflow), .o_underflow(o_underflow)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] flags();
        return 32'({o_invalid, o_div_by_zero, o_overflow, o_underflow});
    endfunction

    // Exact quotient of normalised integer mantissas, then RNE on the integer remainder bits.
    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] o, output logic [3:0] fl, output int lat);
        longint unsigned fa, fb, ma, mb, q, rem, rest, half, mant;
        int  ea, eb, p, e, sh;
        bit  s, an, bn, ai, bi, az, bz, up, inex;
        ea = int'(a[30:23]); eb = int'(b[30:23]);
        fa = 64'(a[22:0]);   fb = 64'(b[22:0]);
        s  = a[31] ^ b[31];
        an = (ea == 255) && (fa != 0); bn = (eb == 255) && (fb != 0);
        ai = (ea == 255) && (fa == 0); bi = (eb == 255) && (fb == 0);
        az = (ea == 0) && (!SUB || fa == 0);
        bz = (eb == 0) && (!SUB || fb == 0);
        o = 32'h0; fl = 4'b0000; lat = 2;
        if (an)                         begin o = a | 32'h0040_0000; fl = 4'b1000; return; end
        if (bn)                         begin o = b | 32'h0040_0000; fl = 4'b1000; return; end
        if ((az && bz) || (ai && bi))   begin o = 32'h7FC0_0000;     fl = 4'b1000; return; end
        if (ai)                         begin o = {s, 8'hFF, 23'h0}; return; end
        if (bz)                         begin o = {s, 8'hFF, 23'h0}; fl = 4'b0100; return; end
        if (az || bi)                   begin o = {s, 31'h0}; return; end
        lat = 29;
        ma = (ea != 0) ? (fa | (64'd1 << 23)) : fa; if (ea == 0) ea = 1;
        mb = (eb != 0) ? (fb | (64'd1 << 23)) : fb; if (eb == 0) eb = 1;
        while (ma < (64'd1 << 23)) begin ma = ma << 1; ea--; lat++; end
        while (mb < (64'd1 << 23)) begin mb = mb << 1; eb--; lat++; end
        q   = (ma << 38) / mb;
        rem = (ma << 38) % mb;
        p   = (q >= (64'd1 << 38)) ? 38 : 37;
        e   = p - 38 + ea - eb + 127;
        if (e < 1 && !SUB) begin o = {s, 31'h0}; fl = 4'b0001; return; end
        sh = p - 23 + ((e < 1) ? (1 - e) : 0);
        if (sh >= 40) begin
            mant = 0; rest = q; up = 1'b0;
        end else begin
            mant = q >> sh;
            rest = q & ((64'd1 << sh) - 1);
            half = 64'd1 << (sh - 1);
            up   = (rest > half) || ((rest == half) && ((rem != 0) || mant[0]));
        end
        inex = (rest != 0) || (rem != 0);
        mant = mant + 64'(up);
        if (e >= 1) begin
            if (mant == (64'd1 << 24)) begin mant = 64'd1 << 23; e++; end
            if (e >= 255) begin o = {s, 8'hFF, 23'h0}; fl = 4'b0010; end
            else          o = {s, e[7:0], mant[22:0]};
        end else begin
            o = {s, mant[30:0]};
            fl[0] = (o[30:23] == 8'h00) && inex;
        end
    endfunction

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] eo,
                          input logic [3:0] ef, input int el, input bit poke);
        int n;
        bit seen;
        @(posedge i_clk); #1;
        chk("idle_busy", 32'(o_busy), 32'd0);
        i_start = 1'b1; i_a = a; i_b = b;
        @(posedge i_clk); #1;
        i_start = 1'b0; i_a = $urandom; i_b = $urandom;
        chk("busy_after_accept", 32'(o_busy), 32'd1);
        n = 0; seen = 1'b0;
        while (!seen && n < 200) begin
            @(posedge i_clk); #1;
            n++;
            i_start = (poke && n == 5);
            if (o_done) seen = 1'b1;
        end
        i_start = 1'b0;
        chk("latency", 32'(n), 32'(el));
        if (seen) begin
            chk("out", o_out, eo);
            chk("flags", flags(), 32'(ef));
            chk("busy_in_done", 32'(o_busy), 32'd1);
            @(posedge i_clk); #1;
            chk("done_pulse", 32'(o_done), 32'd0);
            chk("out_held", o_out, eo);
        end
    endtask

    function automatic logic [31:0] rnd_op();
        logic [31:0] v;
        v = $urandom;
        case ($urandom_range(0, 11))
            0:       v[30:0]  = 31'h0;
            1:       begin v[30:23] = 8'hFF; v[22:0] = 23'h0; end
            2:       begin v[30:23] = 8'hFF; v[0] = 1'b1; end
            3:       v[30:23] = 8'h00;
            4:       v[30:23] = 8'(250 + $urandom_range(0, 4));
            5:       v[30:23] = 8'($urandom_range(1, 8));
            default: v[30:23] = 8'($urandom_range(96, 158));
        endcase
        return v;
    endfunction

    logic [31:0] da [9] = '{32'h40C00000, 32'h3F800000, 32'h3F800000, 32'h00000000, 32'h7F7FFFFF,
                            32'h00800001, 32'hC1000000, 32'hFF800000, 32'h7F800001};
    logic [31:0] db [9] = '{32'h40000000, 32'h40400000, 32'h00000000, 32'h00000000, 32'h3F000000,
                            32'h40000000, 32'h40000000, 32'h7F800000, 32'h3F800000};
    logic [31:0] dq [9] = '{32'h40400000, 32'h3EAAAAAB, 32'h7F800000, 32'h7FC00000, 32'h7F800000,
                            SUB ? 32'h00400000 : 32'h00000000, 32'hC0800000, 32'h7FC00000, 32'h7FC00001};
    logic [3:0]  df [9] = '{4'b0000, 4'b0000, 4'b0100, 4'b1000, 4'b0010, 4'b0001, 4'b0000, 4'b1000, 4'b1000};
    int          dl [9] = '{29, 29, 2, 2, 29, 29, 29, 2, 2};

    initial begin
        logic [31:0] ra, rb, eo;
        logic [3:0]  ef;
        int          el;
        i_rst = 1'b1; i_start = 1'b0; i_a = '0; i_b = '0;
        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_out", o_out, 32'h0);
        chk("rst_done", 32'(o_done), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_flags", flags(), 32'd0);
        i_rst = 1'b0;

        for (int i = 0; i < 9; i++) run_op(da[i], db[i], dq[i], df[i], dl[i], dl[i] > 5);

        // Abort a 6.0/2.0 operation at edge 10; the previous result is non-zero.
        @(posedge i_clk); #1;
        i_start = 1'b1; i_a = 32'h40C00000; i_b = 32'h40000000;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        repeat (10) @(posedge i_clk);
        #1;
        chk("pre_rst_busy", 32'(o_busy), 32'd1);
        i_rst = 1'b1;
        #1;
        chk("abort_busy", 32'(o_busy), 32'd0);
        chk("abort_done", 32'(o_done), 32'd0);
        chk("abort_out", o_out, 32'h0);
        #2 i_rst = 1'b0;
        run_op(32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 29, 1'b0);

        for (int i = 0; i < 250; i++) begin
            ra = rnd_op();
            rb = rnd_op();
            ref_div(ra, rb, eo, ef, el);
            run_op(ra, rb, eo, ef, el, (i % 7 == 0) && el > 5);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
